// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for the serial sequence-detector feeder: state encoding,
// effective-length clamp and saturating-add headroom.
package seq_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StClear = 3'd1,
    StShift = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  // Extra carry bit used so a saturating add can detect overflow.
  localparam int unsigned SatExtW = 1;

  // A length of zero, or one longer than the word, means the whole word.
  function automatic int unsigned eff_len(input int unsigned len, input int unsigned data_w);
    return (len == 0 || len > data_w) ? data_w : len;
  endfunction

endpackage

// File: rtl/seq_hit_counter.sv
// Per-word hit accumulation from detector samples, saturating running total and
// sticky interrupt with its clear.
module seq_hit_counter
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned LenW = 6,
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            word_start_i,
  input  logic            sample_vld_i,
  input  logic            det_out_i,
  input  logic            fin_i,
  input  logic            commit_i,
  input  logic            hits_clr_i,
  output logic [LenW-1:0] word_hits_o,
  output logic [CntW-1:0] total_hits_o,
  output logic            irq_o
);

  localparam int unsigned SumW = ((CntW > LenW) ? CntW : LenW) + SatExtW;
  localparam logic [CntW-1:0] CntMax = '1;

  logic [LenW-1:0] cnt_q, cnt_d;
  logic [LenW-1:0] word_hits_q;
  logic [CntW-1:0] total_q, total_sat;
  logic [SumW-1:0] sum;
  logic            irq_q;

  always_comb begin
    cnt_d     = cnt_q + LenW'(sample_vld_i && det_out_i);
    sum       = SumW'(total_q) + SumW'(cnt_q);
    total_sat = (sum > SumW'(CntMax)) ? CntMax : sum[CntW-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q       <= '0;
      word_hits_q <= '0;
      total_q     <= '0;
      irq_q       <= 1'b0;
    end else begin
      cnt_q <= word_start_i ? '0 : cnt_d;
      // fin_i coincides with the last sample, so take the incremented count.
      if (fin_i) word_hits_q <= cnt_d;
      if (hits_clr_i) total_q <= '0;
      else if (commit_i) total_q <= total_sat;
      // A word with hits re-arms irq even when a clear lands on the same edge.
      if (commit_i && cnt_q != '0) irq_q <= 1'b1;
      else if (hits_clr_i) irq_q <= 1'b0;
    end
  end

  assign word_hits_o  = word_hits_q;
  assign total_hits_o = total_q;
  assign irq_o        = irq_q;

endmodule

// File: rtl/seq_stream_ctrl.sv
// Serialises a word LSB-first into the 4-ones Moore detector, clearing the
// detector before each word and counting the hits it reports.
module seq_stream_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              word_valid,
  output logic              word_ready,
  input  logic [DATA_W-1:0] word_data,
  input  logic [LEN_W-1:0]  word_len,
  input  logic              abort,
  input  logic              hits_clr,
  output logic              det_rst,
  output logic              det_seq,
  input  logic              det_out,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  word_hits,
  output logic [CNT_W-1:0]  total_hits,
  output logic              irq
);

  state_e            state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [LEN_W-1:0]  rem_q;
  logic              det_rst_q, det_seq_q, done_q, sample_vld_q;
  logic              accept, abort_act;
  logic [LEN_W-1:0]  len_eff;

  assign accept    = word_valid && (state_q == StIdle);
  assign abort_act = abort && (state_q == StClear || state_q == StShift || state_q == StDrain);
  assign len_eff   = LEN_W'(eff_len(32'(word_len), DATA_W));

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      shreg_q      <= '0;
      rem_q        <= '0;
      det_rst_q    <= 1'b1;
      det_seq_q    <= 1'b0;
      done_q       <= 1'b0;
      sample_vld_q <= 1'b0;
    end else begin
      det_rst_q    <= 1'b0;
      det_seq_q    <= 1'b0;
      done_q       <= 1'b0;
      // The detector output for a bit is visible the cycle after it is driven.
      sample_vld_q <= (state_q == StShift) && !abort;
      if (abort_act) begin
        state_q   <= StIdle;
        det_rst_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (accept) begin
              shreg_q   <= word_data;
              rem_q     <= len_eff;
              det_rst_q <= 1'b1;
              state_q   <= StClear;
            end
          end
          StClear: begin
            det_seq_q <= shreg_q[0];
            shreg_q   <= shreg_q >> 1;
            rem_q     <= rem_q - 1'b1;
            state_q   <= StShift;
          end
          StShift: begin
            if (rem_q != '0) begin
              det_seq_q <= shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              rem_q     <= rem_q - 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
          StDrain: begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  seq_hit_counter #(
    .LenW(LEN_W),
    .CntW(CNT_W)
  ) u_hit_counter (
    .clk_i       (clock),
    .rst_ni      (reset_n),
    .word_start_i(accept),
    .sample_vld_i(sample_vld_q),
    .det_out_i   (det_out),
    .fin_i       ((state_q == StDrain) && !abort),
    .commit_i    (state_q == StDone),
    .hits_clr_i  (hits_clr),
    .word_hits_o (word_hits),
    .total_hits_o(total_hits),
    .irq_o       (irq)
  );

  assign word_ready = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign det_rst    = det_rst_q;
  assign det_seq    = det_seq_q;
  assign done       = done_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Scoreboard bench for seq_stream_ctrl driving a behavioural 4-ones Moore
// detector; uses a 4-bit total counter so saturation is reachable.
module tb_seq_stream_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 6;
  localparam int unsigned CNT_W  = 4;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              word_valid = 1'b0;
  logic              word_ready;
  logic [DATA_W-1:0] word_data = '0;
  logic [LEN_W-1:0]  word_len = '0;
  logic              abort = 1'b0;
  logic              hits_clr = 1'b0;
  logic              det_rst, det_seq, det_out;
  logic              busy, done, irq;
  logic [LEN_W-1:0]  word_hits;
  logic [CNT_W-1:0]  total_hits;

  int checks = 0;
  int failures = 0;
  int exp_q[$];
  int exp_total = 0;
  int exp_last = 0;
  bit exp_irq = 1'b0;

  always #5 clock = ~clock;

  seq_stream_ctrl #(
    .DATA_W(DATA_W),
    .LEN_W (LEN_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .word_data (word_data),
    .word_len  (word_len),
    .abort     (abort),
    .hits_clr  (hits_clr),
    .det_rst   (det_rst),
    .det_seq   (det_seq),
    .det_out   (det_out),
    .busy      (busy),
    .done      (done),
    .word_hits (word_hits),
    .total_hits(total_hits),
    .irq       (irq)
  );

  // Behavioural detector: states Zero..Four, output high in Four, stays in Four on a 1.
  logic [2:0] dst = 3'd0;
  always_ff @(posedge clock) begin
    if (det_rst) dst <= 3'd0;
    else if (det_seq) dst <= (dst == 3'd4) ? 3'd4 : dst + 3'd1;
    else dst <= 3'd0;
  end
  assign det_out = (dst == 3'd4);

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int ref_hits(input logic [31:0] d, input int n);
    int run = 0;
    int h = 0;
    for (int i = 0; i < n; i++) begin
      run = d[i] ? run + 1 : 0;
      if (run >= 4) h++;
    end
    return h;
  endfunction

  task automatic model_commit(input int h, input bit clr);
    if (clr) exp_total = 0;
    else exp_total = (exp_total + h > 15) ? 15 : exp_total + h;
    if (h != 0) exp_irq = 1'b1;
    else if (clr) exp_irq = 1'b0;
    exp_last = h;
  endtask

  task automatic send_word(input logic [31:0] d, input int len, input bit clr_at_done);
    int n, cyc, h;
    logic [31:0] seen, mask;
    n = (len == 0 || len > 32) ? 32 : len;
    mask = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    cyc = 0;
    while (!word_ready && cyc < 100) begin
      step();
      cyc++;
    end
    word_data  = d;
    word_len   = 6'(len);
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    exp_q.push_back(ref_hits(d, n));
    check_eq("clear_det_rst", det_rst, 1);
    seen = '0;
    for (int i = 0; i < n; i++) begin
      step();
      seen[i] = det_seq;
    end
    cyc = n + 1;
    while (!done && cyc < n + 20) begin
      step();
      cyc++;
    end
    check_eq("latency", cyc, n + 3);
    check_eq("det_seq_bits", seen, d & mask);
    if (exp_q.size() == 0) begin
      check_eq("scoreboard_empty", 1, 0);
      h = 0;
    end else begin
      h = exp_q.pop_front();
    end
    check_eq("word_hits", word_hits, h);
    if (clr_at_done) hits_clr = 1'b1;
    step();
    hits_clr = 1'b0;
    model_commit(h, clr_at_done);
    check_eq("done_pulse", done, 0);
    check_eq("total_hits", total_hits, exp_total);
    check_eq("irq", irq, exp_irq);
    check_eq("ready_after", word_ready, 1);
  endtask

  task automatic pulse_clr();
    hits_clr = 1'b1;
    step();
    hits_clr = 1'b0;
    exp_total = 0;
    exp_irq = 1'b0;
    check_eq("clr_total", total_hits, 0);
    check_eq("clr_irq", irq, 0);
  endtask

  initial begin
    int seen_done;
    repeat (3) step();
    check_eq("rst_det_rst", det_rst, 1);
    check_eq("rst_det_seq", det_seq, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_word_hits", word_hits, 0);
    check_eq("rst_total", total_hits, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", word_ready, 1);
    reset_n = 1'b1;
    step();
    check_eq("idle_det_rst", det_rst, 0);

    send_word(32'h0000_000F, 4, 1'b0);
    pulse_clr();
    send_word(32'h0000_00FF, 8, 1'b0);
    send_word(32'h0000_0077, 8, 1'b0);
    send_word(32'h0000_0003, 2, 1'b0);
    send_word(32'h0000_0003, 2, 1'b0);
    send_word(32'hFFFF_FFFF, 0, 1'b0);
    send_word(32'hFFFF_FFFF, 40, 1'b0);

    // Abort in the third SHIFT cycle.
    word_data = 32'h0000_00FF;
    word_len = 6'd8;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (3) step();
    check_eq("abort_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_eq("abort_det_rst", det_rst, 1);
    check_eq("abort_ready", word_ready, 1);
    seen_done = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done) seen_done++;
    end
    check_eq("abort_no_done", seen_done, 0);
    check_eq("abort_det_rst_off", det_rst, 0);
    check_eq("abort_word_hits", word_hits, exp_last);
    check_eq("abort_total", total_hits, exp_total);

    pulse_clr();
    for (int i = 0; i < 4; i++) send_word(32'h0000_00FF, 8, 1'b0);
    send_word(32'h0000_00FF, 8, 1'b1);

    // Reset in the middle of SHIFT.
    word_data = 32'h0000_00FF;
    word_len = 6'd8;
    word_valid = 1'b1;
    step();
    word_valid = 1'b0;
    repeat (3) step();
    reset_n = 1'b0;
    hits_clr = 1'b1;
    step();
    hits_clr = 1'b0;
    exp_total = 0;
    exp_irq = 1'b0;
    exp_last = 0;
    check_eq("mid_rst_det_rst", det_rst, 1);
    check_eq("mid_rst_det_seq", det_seq, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_irq", irq, 0);
    check_eq("mid_rst_word_hits", word_hits, 0);
    check_eq("mid_rst_total", total_hits, 0);
    reset_n = 1'b1;
    step();
    send_word(32'h0000_000F, 4, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Sequencer that feeds the 4-ones Moore sequence detector from a parallel word interface.
- Accepts a word plus a bit count over a valid/ready handshake, clears the detector, then shifts the bits in LSB-first, one per cycle.
- Samples the detector output for each bit and counts hits per word and in total; raises a done pulse and an interrupt.
- Sits between the user-area bus/IO glue and the detector instance.

Parameters:
- DATA_W, 32, width of the word to be serialised (power of two, ≥4).
- LEN_W, 6, width of word_len; must satisfy 2^(LEN_W-1) ≥ DATA_W.
- CNT_W, 16, width of the saturating total-hit counter.

Ports:
- clock  in  1  single clock for the block and the detector.
- reset_n  in  1  synchronous, active-low reset.
- word_valid  in  1  a word is offered.
- word_ready  out  1  block can accept a word (IDLE only).
- word_data  in  DATA_W  bits to shift, bit 0 sent first.
- word_len  in  LEN_W  number of bits to send; 0 or >DATA_W means DATA_W.
- abort  in  1  synchronous abort of the current word.
- hits_clr  in  1  clears total_hits.
- det_rst  out  1  active-high reset to the detector.
- det_seq  out  1  serial bit to the detector's sequence input.
- det_out  in  1  detector output (Moore, reflects state after last edge).
- busy  out  1  not in IDLE.
- done  out  1  one-cycle pulse when a word completes.
- word_hits  out  LEN_W  hits counted in the last completed word.
- total_hits  out  CNT_W  saturating hit count across words.
- irq  out  1  sticky; set on done with word_hits≠0, cleared by hits_clr.

Behaviour:
- Reset (reset_n=0 at an edge) gives:
  - state=IDLE, det_rst=1, det_seq=0, done=0, irq=0;
  - word_hits=0, total_hits=0; internal shift register and counters 0.
- All outputs are registered except word_ready and busy, which decode state.
- States: IDLE → CLEAR → SHIFT → DRAIN → DONE → IDLE.
- IDLE:
  - word_ready=1; det_rst=0 after the first post-reset cycle; det_seq=0.
  - On word_valid&word_ready: capture word_data and the effective length (clamp rule above), zero the per-word hit count, go to CLEAR.
- CLEAR: det_rst=1 for exactly one cycle; the detector starts every word in its Zero state.
- SHIFT:
  - det_seq = shreg[0] each cycle, then shreg shifts right and remaining decrements.
  - Leave for DRAIN when the last bit has been driven, i.e. effective-length cycles in SHIFT.
- Sampling:
  - A sample_vld flag is delayed one cycle from "bit driven".
  - When sample_vld=1 and det_out=1, the per-word count increments.
  - Overlapping matches count: 6 consecutive ones give 3 hits.
- DRAIN: one cycle, samples the result of the final bit; det_seq=0.
- DONE:
  - done=1 for one cycle; word_hits gets the per-word count.
  - total_hits += per-word count, saturating at 2^CNT_W-1.
  - irq set if per-word count≠0. Then go to IDLE.
- Latency: handshake at edge 0 → done asserted in cycle len+3 (CLEAR 1, SHIFT len, DRAIN 1, DONE 1).
- abort in CLEAR/SHIFT/DRAIN:
  - Next state IDLE; det_rst=1 for one cycle.
  - No done; word_hits and total_hits unchanged.
  - abort in IDLE or DONE is ignored; DONE completes normally.
- hits_clr: total_hits=0 and irq=0 next edge.
  - If coincident with DONE, the clear wins for total_hits, but irq is set if this word had hits.
- reset_n low mid-operation overrides everything, including abort and hits_clr.
- A word_valid held while busy is not accepted (ready low); the data must be held stable until accepted.

Decomposition:
- Shared package seq_ctrl_pkg holds:
  - state encoding constants (IDLE, CLEAR, SHIFT, DRAIN, DONE, 3 bits);
  - the clamp function for effective length;
  - the saturating-add width constant.
- One natural sub-module, seq_hit_counter: sample_vld/det_out accumulation, saturating total, and irq/hits_clr logic.
- Test top instantiates seq_stream_ctrl with Sequence_Detector_MOORE_Verilog:
  - det_rst to the detector's reset;
  - det_seq to its sequence input;
  - det_out from its output.

Test Plan:
- word_data=0x0000000F, len=4 → det_seq 1,1,1,1; done in cycle 7 after accept; word_hits=1, total_hits=1, irq=1.
- word_data=0x000000FF, len=8 → word_hits=5 (overlapping); then 0x00000077, len=8 → word_hits=0, total_hits stays 5.
- Two words 0x3 len=2, back to back → word_hits=0 each; the CLEAR between words prevents cross-word matches.
- len=0 with word_data=0xFFFFFFFF → 32 bits sent, word_hits=29; len=40 gives the same result.
- abort asserted in the third SHIFT cycle of 0xFF/len 8 → no done, det_rst pulses, word_ready back next cycle, counts unchanged.
- CNT_W=4, repeat 0xFF/len 8 four times → total_hits saturates at 15. Then:
  - hits_clr coincident with DONE → total_hits=0, irq=1.
  - reset_n=0 mid-SHIFT → all outputs return to their reset values at the next edge.
